sdram_readback: RTL and testbench

Avalon-MM read master that streams a captured record region back out of SDRAM after a fill completes. It sits downstream of the SDRAM capture writer, sharing the same `sdram_clk` domain and the same address ring bounds (`ring_start`/`ring_end`). It issues single-word pipelined reads from a start address, wraps at the ring end, and delivers words in order on a 256-bit valid/ready stream toward the host-transfer logic. Throughput is credit-limited so backpressure never overflows its internal buffer.

---
 rtl/la_sdram_pkg.sv | 16 +
 rtl/sdram_rb_fifo.sv | 54 +++++
 rtl/sdram_readback.sv | 160 ++++++++++++++++
 tb/tb_sdram_readback.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_sdram_pkg.sv
// Shared SDRAM definitions for the capture writer and the readback master.
// Address/data widths and the readback FSM state encoding.
package la_sdram_pkg;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 256;
    localparam int BE_W   = 32;

    typedef enum logic [1:0] {
        RB_IDLE,
        RB_ISSUE,
        RB_DRAIN,
        RB_FLUSH
    } rb_state_t;

endpackage

// File: rtl/sdram_rb_fifo.sv
// Show-ahead output buffer for SDRAM readback data.
// The head word is visible on q the cycle after it is pushed.
module sdram_rb_fifo
    import la_sdram_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   sdram_clk,
    input  logic                   sdram_rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic [DATA_W-1:0]      data,
    input  logic                   pop,
    output logic [DATA_W-1:0]      q,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (level == '0);
    assign do_push = push && (level != (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign q       = mem[rd_ptr];

    always_ff @(posedge sdram_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_ptr + PW'(do_pop);
            level  <= level + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/sdram_readback.sv
// Avalon-MM read master streaming a ring-buffered SDRAM region out on a 256-bit
// valid/ready stream, credit-limited so the output buffer can never overflow.
module sdram_readback
    import la_sdram_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic              sdram_clk,
    input  logic              sdram_rst,
    input  logic              rd_launch,
    input  logic              rd_abort,
    input  logic [ADDR_W-1:0] rd_addr_start,
    input  logic [ADDR_W-1:0] rd_count,
    input  logic [ADDR_W-1:0] ring_start,
    input  logic [ADDR_W-1:0] ring_end,
    output logic              rd_busy,
    output logic              rd_done,
    output logic [ADDR_W-1:0] sdram_address,
    output logic [7:0]        sdram_burstcount,
    output logic              sdram_read,
    input  logic              sdram_waitrequest,
    input  logic [DATA_W-1:0] sdram_readdata,
    input  logic              sdram_readdatavalid,
    output logic              sdram_write,
    output logic [DATA_W-1:0] sdram_writedata,
    output logic [BE_W-1:0]   sdram_byteenable,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    rb_state_t         state;
    logic [LW-1:0]     outstanding;
    logic [LW-1:0]     outstanding_nxt;
    logic [LW-1:0]     fifo_level;
    logic [LW:0]       credit_sum;
    logic              credit_ok;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_q;
    logic              fifo_push;
    logic              fifo_clr;
    logic              accept;
    logic              ret;
    logic              handshake;
    logic [ADDR_W-1:0] issue_remain;
    logic [ADDR_W-1:0] deliver_remain;
    logic [ADDR_W-1:0] ring_start_q;
    logic [ADDR_W-1:0] ring_end_q;
    logic [ADDR_W-1:0] next_addr;

    assign sdram_burstcount = 8'd1;
    assign sdram_write      = 1'b0;
    assign sdram_writedata  = '0;
    assign sdram_byteenable = '1;

    assign accept          = sdram_read && !sdram_waitrequest;
    assign ret             = sdram_readdatavalid && (state != RB_IDLE) && (outstanding != '0);
    assign outstanding_nxt = outstanding + LW'(accept) - LW'(ret);

    // Credit counts this cycle's acceptance, since sdram_read is registered and
    // a read raised now may be accepted before the counters catch up.
    assign credit_sum = (LW+1)'(outstanding) + (LW+1)'(fifo_level) + (LW+1)'(accept);
    assign credit_ok  = credit_sum < (LW+1)'(FIFO_DEPTH);

    assign fifo_push = ret && (state != RB_FLUSH);
    assign fifo_clr  = (state == RB_FLUSH);
    assign out_valid = !fifo_empty && (state != RB_FLUSH);
    assign handshake = out_valid && out_ready;
    assign out_data  = out_valid ? fifo_q : '0;
    assign out_last  = out_valid && (deliver_remain == ADDR_W'(1));
    assign rd_busy   = (state != RB_IDLE);
    assign next_addr = (sdram_address == ring_end_q) ? ring_start_q : sdram_address + ADDR_W'(1);

    sdram_rb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sdram_clk (sdram_clk),
        .sdram_rst (sdram_rst),
        .clr       (fifo_clr),
        .push      (fifo_push),
        .data      (sdram_readdata),
        .pop       (handshake),
        .q         (fifo_q),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state          <= RB_IDLE;
            sdram_read     <= 1'b0;
            sdram_address  <= '0;
            rd_done        <= 1'b0;
            outstanding    <= '0;
            issue_remain   <= '0;
            deliver_remain <= '0;
            ring_start_q   <= '0;
            ring_end_q     <= '0;
        end else begin
            rd_done     <= 1'b0;
            outstanding <= outstanding_nxt;
            if (handshake && deliver_remain != '0) begin
                deliver_remain <= deliver_remain - ADDR_W'(1);
            end
            case (state)
                RB_IDLE: begin
                    if (rd_launch) begin
                        if (rd_count == '0) begin
                            rd_done <= 1'b1;
                        end else begin
                            sdram_address  <= rd_addr_start;
                            sdram_read     <= 1'b1;
                            issue_remain   <= rd_count;
                            deliver_remain <= rd_count;
                            ring_start_q   <= ring_start;
                            ring_end_q     <= ring_end;
                            state          <= RB_ISSUE;
                        end
                    end
                end
                RB_ISSUE: begin
                    if (rd_abort) begin
                        sdram_read <= 1'b0;
                        state      <= RB_FLUSH;
                    end else if (accept) begin
                        sdram_address <= next_addr;
                        issue_remain  <= issue_remain - ADDR_W'(1);
                        if (issue_remain == ADDR_W'(1)) begin
                            sdram_read <= 1'b0;
                            state      <= RB_DRAIN;
                        end else begin
                            sdram_read <= credit_ok;
                        end
                    end else if (!sdram_read) begin
                        sdram_read <= credit_ok;
                    end
                end
                RB_DRAIN: begin
                    if (rd_abort) begin
                        state <= RB_FLUSH;
                    end else if (handshake && deliver_remain == ADDR_W'(1)) begin
                        rd_done <= 1'b1;
                        state   <= RB_IDLE;
                    end
                end
                RB_FLUSH: begin
                    if (outstanding_nxt == '0) begin
                        rd_done <= 1'b1;
                        state   <= RB_IDLE;
                    end
                end
                default: state <= RB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_readback.sv
// Directed bench for sdram_readback: a latency-3 Avalon slave model and a
// scoreboard of expected addresses and stream words filled at each launch.
module tb_sdram_readback;
    import la_sdram_pkg::*;

    localparam int DEPTH = 16;
    localparam int LAT   = 3;

    logic              sdram_clk = 1'b0;
    logic              sdram_rst;
    logic              rd_launch;
    logic              rd_abort;
    logic [ADDR_W-1:0] rd_addr_start;
    logic [ADDR_W-1:0] rd_count;
    logic [ADDR_W-1:0] ring_start;
    logic [ADDR_W-1:0] ring_end;
    logic              rd_busy;
    logic              rd_done;
    logic [ADDR_W-1:0] sdram_address;
    logic [7:0]        sdram_burstcount;
    logic              sdram_read;
    logic              sdram_waitrequest;
    logic [DATA_W-1:0] sdram_readdata;
    logic              sdram_readdatavalid;
    logic              sdram_write;
    logic [DATA_W-1:0] sdram_writedata;
    logic [BE_W-1:0]   sdram_byteenable;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    sdram_readback #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sdram_clk           (sdram_clk),
        .sdram_rst           (sdram_rst),
        .rd_launch           (rd_launch),
        .rd_abort            (rd_abort),
        .rd_addr_start       (rd_addr_start),
        .rd_count            (rd_count),
        .ring_start          (ring_start),
        .ring_end            (ring_end),
        .rd_busy             (rd_busy),
        .rd_done             (rd_done),
        .sdram_address       (sdram_address),
        .sdram_burstcount    (sdram_burstcount),
        .sdram_read          (sdram_read),
        .sdram_waitrequest   (sdram_waitrequest),
        .sdram_readdata      (sdram_readdata),
        .sdram_readdatavalid (sdram_readdatavalid),
        .sdram_write         (sdram_write),
        .sdram_writedata     (sdram_writedata),
        .sdram_byteenable    (sdram_byteenable),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_last            (out_last)
    );

    always #5 sdram_clk = ~sdram_clk;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] exp_addr[$];
    logic [DATA_W-1:0] exp_data[$];
    logic              exp_last[$];
    logic [ADDR_W-1:0] pend_addr[$];
    logic [7:0]        pend_salt[$];
    int                pend_due[$];

    logic [7:0] salt = 8'd0;
    int  cyc = 0, acc_cnt = 0, acc_base = 0;
    int  first_rdv = -1, first_hs = -1, last_hs = -1;
    bit  ready_en = 1'b1, stall_en = 1'b0, flushing = 1'b0;
    bit  chk_done_timing = 1'b0, done_seen = 1'b0;
    bit  prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] data_fn(input logic [ADDR_W-1:0] a, input logic [7:0] s);
        logic [DATA_W-1:0] d;
        for (int k = 0; k < 8; k++) begin
            d[k*32 +: 32] = {s[4:0], a} + 32'(k);
        end
        return d;
    endfunction

    // Slave model and stream monitor, all at the falling edge.
    initial begin
        sdram_waitrequest   = 1'b0;
        sdram_readdatavalid = 1'b0;
        sdram_readdata      = '0;
        out_ready           = 1'b0;
        forever begin
            @(negedge sdram_clk);
            cyc++;
            if (prev_stall && !flushing) begin
                check("stall_hold_read", sdram_read, 1);
                check("stall_hold_addr", sdram_address, prev_addr);
            end
            sdram_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
            prev_stall = sdram_read && sdram_waitrequest;
            prev_addr  = sdram_address;
            if (sdram_read && !sdram_waitrequest) begin
                acc_cnt++;
                check("read_expected", DATA_W'(exp_addr.size() != 0), 1);
                if (exp_addr.size() != 0) check("read_addr", sdram_address, exp_addr.pop_front());
                pend_addr.push_back(sdram_address);
                pend_salt.push_back(salt);
                pend_due.push_back(cyc + LAT);
            end
            if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
                void'(pend_due.pop_front());
                sdram_readdatavalid = 1'b1;
                sdram_readdata      = data_fn(pend_addr.pop_front(), pend_salt.pop_front());
                if (first_rdv < 0) first_rdv = cyc;
            end else begin
                sdram_readdatavalid = 1'b0;
                sdram_readdata      = '1;
            end
            out_ready = ready_en;
            if (flushing) begin
                check("flush_out_valid", out_valid, 0);
            end else if (out_valid && out_ready) begin
                check("word_expected", DATA_W'(exp_data.size() != 0), 1);
                if (exp_data.size() != 0) begin
                    if (first_hs < 0) first_hs = cyc;
                    if (exp_last[0]) last_hs = cyc;
                    check("out_last", out_last, exp_last.pop_front());
                    check("out_data", out_data, exp_data.pop_front());
                end
            end
            if (rd_done) begin
                done_seen = 1'b1;
                if (chk_done_timing) check("done_timing", cyc, last_hs + 1);
            end
        end
    end

    task automatic launch(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] n,
                          input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] re);
        logic [ADDR_W-1:0] ad;
        salt++;
        ad = a;
        for (int unsigned i = 0; i < n; i++) begin
            exp_addr.push_back(ad);
            exp_data.push_back(data_fn(ad, salt));
            exp_last.push_back(i == n - 1);
            ad = (ad == re) ? rs : ad + ADDR_W'(1);
        end
        done_seen = 1'b0;
        first_rdv = -1;
        first_hs  = -1;
        acc_base  = acc_cnt;
        rd_addr_start = a;
        rd_count      = n;
        ring_start    = rs;
        ring_end      = re;
        rd_launch     = 1'b1;
        @(posedge sdram_clk); #2;
        rd_launch = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int k = 0;
        while (!done_seen && k < max_cyc) begin
            @(posedge sdram_clk); #2;
            k++;
        end
        check(tag, done_seen, 1);
    endtask

    task automatic check_clean(input string tag);
        check({tag, "_addr_left"}, exp_addr.size(), 0);
        check({tag, "_word_left"}, exp_data.size(), 0);
        check({tag, "_busy"}, rd_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rd_launch = 1'b0; rd_abort = 1'b0;
        rd_addr_start = '0; rd_count = '0; ring_start = '0; ring_end = '0;
        sdram_rst = 1'b1;
        repeat (3) @(posedge sdram_clk);
        #2;
        check("rst_read", sdram_read, 0);
        check("rst_addr", sdram_address, 0);
        check("rst_burst", sdram_burstcount, 1);
        check("rst_be", sdram_byteenable, 32'hFFFF_FFFF);
        check("rst_write", sdram_write, 0);
        check("rst_wdata", sdram_writedata, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", rd_busy, 0);
        check("rst_done", rd_done, 0);
        sdram_rst = 1'b0;
        @(posedge sdram_clk); #2;

        // Linear read
        chk_done_timing = 1'b1;
        launch(27'h10, 27'd4, 27'h0, 27'hFF);
        check("lin_read_t1", sdram_read, 1);
        check("lin_addr_t1", sdram_address, 27'h10);
        check("lin_busy", rd_busy, 1);
        wait_done("lin_done", 100);
        check("lin_valid_latency", first_hs, first_rdv + 1);
        check("lin_accepts", acc_cnt - acc_base, 4);
        check_clean("lin");

        // Ring wrap
        launch(27'h102, 27'd5, 27'h100, 27'h103);
        wait_done("wrap_done", 100);
        check_clean("wrap");

        // Backpressure: credit caps reads at the buffer depth
        ready_en = 1'b0;
        launch(27'h200, 27'd40, 27'h0, 27'hFFF);
        repeat (40) @(posedge sdram_clk);
        #2;
        check("bp_accepts", acc_cnt - acc_base, DEPTH);
        check("bp_read_idle", sdram_read, 0);
        ready_en = 1'b1;
        wait_done("bp_done", 400);
        check("bp_total_accepts", acc_cnt - acc_base, 40);
        check_clean("bp");

        // Random waitrequest, crossing ring end and the 2^27 boundary
        stall_en = 1'b1;
        launch(27'h7FF_FFFD, 27'd12, 27'h0, 27'h7FF_FFFF);
        wait_done("stall_done", 600);
        stall_en = 1'b0;
        check_clean("stall");

        // Abort with reads outstanding
        chk_done_timing = 1'b0;
        launch(27'h400, 27'd20, 27'h0, 27'hFFF);
        k = 0;
        while (acc_cnt - acc_base < 5 && k < 50) begin
            @(posedge sdram_clk); #2;
            k++;
        end
        check("abort_reach5", DATA_W'(acc_cnt - acc_base >= 5), 1);
        rd_abort = 1'b1;
        @(posedge sdram_clk); #2;
        rd_abort = 1'b0;
        flushing = 1'b1;
        check("abort_read_drop", sdram_read, 0);
        wait_done("abort_done", 100);
        check("abort_pending_empty", pend_due.size(), 0);
        repeat (5) @(posedge sdram_clk);
        #2;
        check("abort_accepts", acc_cnt - acc_base, 6);
        check("abort_busy", rd_busy, 0);
        exp_addr.delete();
        exp_data.delete();
        exp_last.delete();
        flushing = 1'b0;

        // Relaunch after abort
        chk_done_timing = 1'b1;
        launch(27'h20, 27'd6, 27'h0, 27'hFF);
        wait_done("relaunch_done", 100);
        check_clean("relaunch");

        // Zero count
        chk_done_timing = 1'b0;
        launch(27'h30, 27'd0, 27'h0, 27'hFF);
        check("zero_done_t1", rd_done, 1);
        check("zero_busy", rd_busy, 0);
        check("zero_read", sdram_read, 0);
        @(posedge sdram_clk); #2;
        check("zero_done_pulse", rd_done, 0);
        repeat (5) @(posedge sdram_clk);
        #2;
        check("zero_accepts", acc_cnt - acc_base, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
